fifo_1r1w_sync: RTL and testbench

- Ready/valid FIFO that wraps one ram_1r1w_sync storage instance and owns all pointer, flag and read-latency handling around it.
- Sits between the UART RX byte stream and the ALU packet parser, buffering bytes while the parser is busy.
- Hides the RAM's 1-cycle synchronous read so the consumer sees first-word-fall-through data.

---
 rtl/fifo_1r1w_sync.sv | 116 +++++++++++
 tb/tb_fifo_1r1w_sync.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_1r1w_sync.sv
// Ready/valid first-word-fall-through FIFO around a 1-cycle synchronous-read RAM.
// Optional occupancy output enabled by defining FIFO_COUNT_EN; otherwise count_o is tied to 0.

module ram_1r1w_sync #(
  parameter int width_p = 8,
  parameter int els_p   = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       w_v_i,
  input  logic [$clog2(els_p)-1:0]   w_addr_i,
  input  logic [width_p-1:0]         w_data_i,
  input  logic                       rd_valid_i,
  input  logic [$clog2(els_p)-1:0]   rd_addr_i,
  output logic [width_p-1:0]         rd_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  // Read returns the pre-write contents on an address collision.
  always_ff @(posedge clk_i) begin
    if (reset_i)         rd_data_o <= '0;
    else if (rd_valid_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

module fifo_1r1w_sync #(
  parameter int width_p = 8,
  parameter int depth_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       ready_i,
  output logic [$clog2(depth_p):0]   count_o
);

  localparam int addr_w = $clog2(depth_p);
  localparam int ptr_w  = addr_w + 1;

  logic [ptr_w-1:0]   wr_ptr;
  logic [ptr_w-1:0]   rd_ptr;
  logic [ptr_w-1:0]   rd_ptr_next;
  logic               empty;
  logic               full;
  logic               enq;
  logic               deq;
  logic               bypass_hit;
  logic               bypass_v;
  logic [width_p-1:0] bypass_r;
  logic [width_p-1:0] ram_rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[addr_w-1:0] == rd_ptr[addr_w-1:0]) &&
                 (wr_ptr[addr_w] != rd_ptr[addr_w]);

  assign ready_o = ~full & ~reset_i;
  assign valid_o = ~empty;

  assign enq = valid_i & ready_o;
  assign deq = valid_o & ready_i;

  // Reading at the post-dequeue head lets the RAM output line up with the next cycle's head.
  assign rd_ptr_next = rd_ptr + {{addr_w{1'b0}}, deq};

  // A write landing on the address being read this cycle would be missed by the RAM.
  assign bypass_hit = enq && (wr_ptr[addr_w-1:0] == rd_ptr_next[addr_w-1:0]);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      bypass_v <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + {{addr_w{1'b0}}, 1'b1};
      rd_ptr   <= rd_ptr_next;
      bypass_v <= bypass_hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (bypass_hit) bypass_r <= data_i;
  end

  ram_1r1w_sync #(
    .width_p (width_p),
    .els_p   (depth_p)
  ) storage (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .w_v_i      (enq),
    .w_addr_i   (wr_ptr[addr_w-1:0]),
    .w_data_i   (data_i),
    .rd_valid_i (1'b1),
    .rd_addr_i  (rd_ptr_next[addr_w-1:0]),
    .rd_data_o  (ram_rd_data)
  );

  assign data_o = bypass_v ? bypass_r : ram_rd_data;

`ifdef FIFO_COUNT_EN
  assign count_o = wr_ptr - rd_ptr;
`else
  assign count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_1r1w_sync.sv
// Directed bench for fifo_1r1w_sync: reset, FWFT latency, full/empty, streaming, random traffic, mid-stream reset.
// Count expectations follow FIFO_COUNT_EN when it is defined for the build.

module tb_fifo_1r1w_sync;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i;
  logic [4:0] count_o;

  int vectors = 0;
  int miscompares = 0;

  fifo_1r1w_sync #(.width_p(8), .depth_p(16)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [4:0] ec(input int n);
`ifdef FIFO_COUNT_EN
    ec = 5'(n);
`else
    ec = 5'(n) & 5'd0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = 8'h00;
    tick; tick;
    @(negedge clk_i);
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    vectors++; if (count_o !== ec(0)) begin miscompares++; $display("FAIL rst_count: got %0d want %0d", count_o, ec(0)); end
    tick;
    reset_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %b want 1", ready_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_valid: got %b want 0", valid_o); end
    tick;
  endtask

  task automatic test_single;
    valid_i = 1'b1; data_i = 8'hA5; ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL single_pre_valid: got %b want 0", valid_o); end
    tick;
    valid_i = 1'b0; data_i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid[%0d]: got %b want 1", k, valid_o); end
      vectors++; if (data_o !== 8'hA5) begin miscompares++; $display("FAIL single_data[%0d]: got %h want a5", k, data_o); end
      vectors++; if (count_o !== ec(1)) begin miscompares++; $display("FAIL single_count[%0d]: got %0d want %0d", k, count_o, ec(1)); end
      tick;
    end
    ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL single_post_valid: got %b want 0", valid_o); end
    vectors++; if (count_o !== ec(0)) begin miscompares++; $display("FAIL single_post_count: got %0d want %0d", count_o, ec(0)); end
    tick;
  endtask

  task automatic test_fill_drain;
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1; data_i = 8'(i);
      @(negedge clk_i);
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_ready[%0d]: got %b want 1", i, ready_o); end
      vectors++; if (count_o !== ec(i)) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_o, ec(i)); end
      tick;
    end
    valid_i = 1'b1; data_i = 8'h99;
    @(negedge clk_i);
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", ready_o); end
    vectors++; if (count_o !== ec(16)) begin miscompares++; $display("FAIL full_count: got %0d want %0d", count_o, ec(16)); end
    tick;
    valid_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (count_o !== ec(16)) begin miscompares++; $display("FAIL full_17th_count: got %0d want %0d", count_o, ec(16)); end
    tick;
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d]: got %b want 1", i, valid_o); end
      vectors++; if (data_o !== 8'(i)) begin miscompares++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_o, 8'(i)); end
      vectors++; if (count_o !== ec(16 - i)) begin miscompares++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count_o, ec(16 - i)); end
      tick;
    end
    ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got %b want 0", valid_o); end
    tick;
  endtask

  task automatic test_full_simul;
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1; data_i = 8'h20 + 8'(i);
      tick;
    end
    valid_i = 1'b1; data_i = 8'hEE; ready_i = 1'b1;
    @(negedge clk_i);
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL simul_ready: got %b want 0", ready_o); end
    vectors++; if (data_o !== 8'h20) begin miscompares++; $display("FAIL simul_head: got %h want 20", data_o); end
    tick;
    valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL simul_ready_after: got %b want 1", ready_o); end
    vectors++; if (count_o !== ec(15)) begin miscompares++; $display("FAIL simul_count: got %0d want %0d", count_o, ec(15)); end
    tick;
    ready_i = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk_i);
      vectors++; if (data_o !== 8'h20 + 8'(i)) begin miscompares++; $display("FAIL simul_drain[%0d]: got %h want %h", i, data_o, 8'h20 + 8'(i)); end
      tick;
    end
    ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL simul_empty: got %b want 0", valid_o); end
    tick;
  endtask

  task automatic test_stream;
    ready_i = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      valid_i = (k < 40);
      data_i  = 8'h10 + 8'(k);
      @(negedge clk_i);
      if (k == 0) begin
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL stream_first_valid: got %b want 0", valid_o); end
      end else begin
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", k, valid_o); end
        vectors++; if (data_o !== 8'h10 + 8'(k - 1)) begin miscompares++; $display("FAIL stream_data[%0d]: got %h want %h", k, data_o, 8'h10 + 8'(k - 1)); end
        vectors++; if (count_o !== ec(1)) begin miscompares++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, count_o, ec(1)); end
      end
      tick;
    end
    valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL stream_end_valid: got %b want 0", valid_o); end
    tick;
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    bit m_enq, m_deq;
    for (int c = 0; c < 1000; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      data_i  = 8'($urandom);
      @(negedge clk_i);
      vectors++; if (valid_o !== (q.size() != 0)) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b want %b", c, valid_o, q.size() != 0); end
      if (q.size() != 0) begin
        vectors++; if (data_o !== q[0]) begin miscompares++; $display("FAIL rand_data[%0d]: got %h want %h", c, data_o, q[0]); end
      end
      vectors++; if (ready_o !== (q.size() < 16)) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", c, ready_o, q.size() < 16); end
      vectors++; if (count_o !== ec(q.size())) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, count_o, ec(q.size())); end
      m_deq = ready_i && (q.size() != 0);
      m_enq = valid_i && (q.size() < 16);
      if (m_deq) void'(q.pop_front());
      if (m_enq) q.push_back(data_i);
      tick;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < 17 && q.size() != 0; c++) begin
      @(negedge clk_i);
      vectors++; if (data_o !== q[0]) begin miscompares++; $display("FAIL rand_drain[%0d]: got %h want %h", c, data_o, q[0]); end
      void'(q.pop_front());
      tick;
    end
    ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rand_empty: got %b want 0", valid_o); end
    tick;
  endtask

  task automatic test_mid_reset;
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; data_i = 8'h50 + 8'(i);
      tick;
    end
    reset_i = 1'b1; valid_i = 1'b1; data_i = 8'h77;
    @(negedge clk_i);
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b want 0", ready_o); end
    tick;
    reset_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
    vectors++; if (count_o !== ec(0)) begin miscompares++; $display("FAIL midrst_count: got %0d want %0d", count_o, ec(0)); end
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_after: got %b want 1", ready_o); end
    tick;
    valid_i = 1'b1; data_i = 8'h3C;
    tick;
    valid_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL midrst_head_valid: got %b want 1", valid_o); end
    vectors++; if (data_o !== 8'h3C) begin miscompares++; $display("FAIL midrst_head_data: got %h want 3c", data_o); end
    vectors++; if (count_o !== ec(1)) begin miscompares++; $display("FAIL midrst_head_count: got %0d want %0d", count_o, ec(1)); end
    tick;
    ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_final_empty: got %b want 0", valid_o); end
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_fill_drain;
    test_full_simul;
    test_stream;
    test_random;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
